autoconfig_master_sequencer: RTL
================================

# autoconfig_master_sequencer

Master-side sequencer for UART autoconfiguration. After the line-setup phase it transmits the three configuration packets (data width, stop bits, parity mode) through the TX FIFO, in that order. After each packet it waits for a 0xFF acknowledge from the RX FIFO. Missing or wrong acknowledges are retried up to a bounded count. The block sits between the main controller (start/result) and the TX/RX FIFO ports, and owns the TX FIFO write port only while busy.

## Interface
- TIMEOUT_CYCLES, 5_000_000, clock cycles to wait for an acknowledge (50 ms at 100 MHz)
- MAX_RETRY, 3, transmissions allowed per packet before failing (≥1)
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high (fixed)
- start_i  in  1  begin sequence; sampled only in IDLE
- data_width_i  in  2  requested data width option
- stop_bits_i  in  2  requested stop bits option
- parity_mode_i  in  2  requested parity mode option
- tx_fifo_full_i  in  1  TX FIFO full
- tx_fifo_write_o  out  1  TX FIFO write strobe
- tx_data_o  out  8  packet byte for TX FIFO
- rx_fifo_empty_i  in  1  RX FIFO empty
- rx_fifo_read_o  out  1  RX FIFO read strobe; FIFO is first-word-fall-through
- rx_data_i  in  8  RX FIFO head byte, valid while not empty
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse: all three packets acknowledged
- fail_o  out  1  one-cycle pulse: retries exhausted
- fail_field_o  out  2  packet ID that failed; held until next start

## Operation
- Packet format: [7:4]=0, [3:2]=ID, [1:0]=option. IDs: DATA_WIDTH_ID=2'b01, STOP_BITS_ID=2'b10, PARITY_MODE_ID=2'b11. ACK byte = 8'hFF.
- On accepted start, the three option inputs are snapshot into registers. Later input changes have no effect until the next start.
- States:
  - IDLE: start_i → SEND, field=DATA_WIDTH_ID, retry=0.
  - SEND: tx_fifo_write_o=!tx_fifo_full_i, tx_data_o=packet(field). On the write cycle → WAIT_ACK, timer cleared. While full, stay in SEND; the timer does not run.
  - WAIT_ACK: timer increments each cycle. If !rx_fifo_empty_i → rx_fifo_read_o=1 for that cycle and → CHECK, with the byte registered.
  - CHECK: byte==8'hFF → advance field (01→10→11), retry=0 → SEND. After PARITY_MODE_ID → DONE. Any other byte → RETRY.
  - Timer reaching TIMEOUT_CYCLES−1 with RX empty → RETRY. If a byte arrives on that same cycle, the byte wins.
  - RETRY: retry+1. If the new count == MAX_RETRY → FAIL, else → SEND with the same field.
  - DONE: done_o=1 → IDLE.
  - FAIL: fail_o=1, fail_field_o=field → IDLE.
- busy_o=1 in every state except IDLE. start_i while busy is ignored.
- Exactly one RX byte is consumed per WAIT_ACK visit. Extra queued bytes are left for the next WAIT_ACK.

## Timing
- Reset values: state IDLE, tx_fifo_write_o=0, tx_data_o=0, rx_fifo_read_o=0, busy_o=0, done_o=0, fail_o=0, fail_field_o=0, counters 0.
- Reset mid-sequence returns to IDLE immediately (asynchronous) with no further FIFO strobes. A partial packet already written stays in the FIFO.
- start_i high at edge N → SEND at N+1 → earliest write at N+1 (combinational from state and full).
- Best-case full sequence with immediate ACKs: 3×(SEND+WAIT_ACK+CHECK) + DONE = 10 cycles from start to done_o.
- Timeout: WAIT_ACK lasts exactly TIMEOUT_CYCLES cycles with RX empty, then RETRY.
- Timer width $clog2(TIMEOUT_CYCLES); it must not wrap within one WAIT_ACK visit.
- tx_data_o and rx_fifo_read_o are combinational from registered state. All other outputs are registered or state-decoded.

## Structure
- UART_pkg gains: cfg ID constants, ACK_BYTE=8'hFF, cfg_packet_t struct {pad[3:0], id[1:0], option[1:0]}, seq_state_e enum (IDLE, SEND, WAIT_ACK, CHECK, RETRY, DONE, FAIL).
- One sub-module: timeout_counter (clear, enable, parameter LIMIT, expired output). It is reused later for the 10 ms/50 ms line timers.

## Test plan
- start, options 2'b11/2'b01/2'b10, ACK 0xFF returned 1 cycle after each write → TX bytes 0x07, 0x09, 0x0E in order, done_o at cycle 10, fail_o never asserted.
- TX FIFO full for 20 cycles after start → no write for 20 cycles, then a single write of 0x07. The timeout does not start until the write.
- First ACK replaced by 0x3C, then 0xFF → 0x07 sent twice, the sequence completes, done_o pulses once.
- TIMEOUT_CYCLES=16, RX silent for the stop-bits packet → three 0x09 writes spaced 16+ cycles, fail_o pulse, fail_field_o=2'b10, busy_o=0.
- ACK arrives on the exact timeout cycle → treated as ACK, no retry.
- rst_i asserted while in WAIT_ACK → all outputs 0 immediately. A new start after release begins again from DATA_WIDTH_ID.

Source files
------------

// File: rtl/autoconfig_master_sequencer_pkg.sv
// Shared types and constants for the UART autoconfiguration master sequencer.
package autoconfig_master_sequencer_pkg;

  localparam int unsigned ID_W     = 2;
  localparam int unsigned OPT_W    = 2;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned STATE_W  = 3;

  // Configuration packet identifiers, sent in this order
  localparam logic [ID_W-1:0] DATA_WIDTH_ID  = 2'b01;
  localparam logic [ID_W-1:0] STOP_BITS_ID   = 2'b10;
  localparam logic [ID_W-1:0] PARITY_MODE_ID = 2'b11;

  // Byte the slave returns to acknowledge a packet
  localparam logic [BYTE_W-1:0] ACK_BYTE = 8'hFF;

  // One configuration byte as placed into the TX FIFO
  typedef struct packed {
    logic [3:0]       pad;
    logic [ID_W-1:0]  id;
    logic [OPT_W-1:0] option;
  } cfg_packet_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    CHECK    = 3'd3,
    RETRY    = 3'd4,
    DONE     = 3'd5,
    FAIL     = 3'd6
  } seq_state_e;

  // Assemble a configuration packet from its ID and option
  function automatic cfg_packet_t make_packet(input logic [ID_W-1:0]  id,
                                              input logic [OPT_W-1:0] option);
    cfg_packet_t pkt;
    pkt.pad    = 4'h0;
    pkt.id     = id;
    pkt.option = option;
    return pkt;
  endfunction

endpackage

// File: rtl/autoconfig_master_sequencer_timeout_counter.sv
// Saturating cycle counter flagging the last cycle of a LIMIT-cycle window.
module autoconfig_master_sequencer_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // Count while enabled, hold at the last value so a window never wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i && (r_count != LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expired during the final enabled cycle of the window
  assign expired_c = enable_i && (r_count == LAST);

endmodule

// File: rtl/autoconfig_master_sequencer.sv
// Sends the three UART configuration packets and collects their acknowledges,
// retrying each packet a bounded number of times.
module autoconfig_master_sequencer
  import autoconfig_master_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [OPT_W-1:0]  data_width_i,
  input  logic [OPT_W-1:0]  stop_bits_i,
  input  logic [OPT_W-1:0]  parity_mode_i,
  input  logic              tx_fifo_full_i,
  output logic              tx_fifo_write_o,
  output logic [BYTE_W-1:0] tx_data_o,
  input  logic              rx_fifo_empty_i,
  output logic              rx_fifo_read_o,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ID_W-1:0]   fail_field_o
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  seq_state_e         r_state;
  seq_state_e         w_next_state;

  logic [ID_W-1:0]    r_field;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_inc;
  logic [OPT_W-1:0]   r_opt_data_width;
  logic [OPT_W-1:0]   r_opt_stop_bits;
  logic [OPT_W-1:0]   r_opt_parity_mode;
  logic [OPT_W-1:0]   w_option;
  logic [BYTE_W-1:0]  r_rx_byte;

  logic               w_timer_clear;
  logic               w_timer_en;
  logic               w_timer_expired;

  logic               r_busy;
  logic               r_done;
  logic               r_fail;
  logic [ID_W-1:0]    r_fail_field;
  logic               w_busy_d;
  logic               w_done_d;
  logic               w_fail_d;
  logic [ID_W-1:0]    w_fail_field_d;

  assign w_retry_inc   = r_retry + RETRY_W'(1);
  assign w_timer_en    = (r_state == WAIT_ACK);
  assign w_timer_clear = (r_state != WAIT_ACK);

  // Acknowledge timer, restarted every time WAIT_ACK is entered
  autoconfig_master_sequencer_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_timer_clear),
    .enable_i  (w_timer_en),
    .expired_c (w_timer_expired)
  );

  // Option belonging to the packet currently being sent
  always_comb begin
    w_option = r_opt_data_width;
    case (r_field)
      STOP_BITS_ID:   w_option = r_opt_stop_bits;
      PARITY_MODE_ID: w_option = r_opt_parity_mode;
      default:        w_option = r_opt_data_width;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an arriving byte takes priority over the timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (!tx_fifo_full_i) begin
          w_next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!rx_fifo_empty_i) begin
          w_next_state = CHECK;
        end else if (w_timer_expired) begin
          w_next_state = RETRY;
        end
      end
      CHECK: begin
        if (r_rx_byte == ACK_BYTE) begin
          w_next_state = (r_field == PARITY_MODE_ID) ? DONE : SEND;
        end else begin
          w_next_state = RETRY;
        end
      end
      RETRY: begin
        w_next_state = (w_retry_inc == RETRY_LIMIT) ? FAIL : SEND;
      end
      DONE:    w_next_state = IDLE;
      FAIL:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: FIFO strobes decoded from the current state, status from the next state
  always_comb begin
    tx_fifo_write_o = 1'b0;
    tx_data_o       = '0;
    rx_fifo_read_o  = 1'b0;
    w_busy_d        = (w_next_state != IDLE);
    w_done_d        = (w_next_state == DONE);
    w_fail_d        = (w_next_state == FAIL);
    w_fail_field_d  = r_fail_field;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_fail_field_d = '0;
        end
      end
      SEND: begin
        tx_fifo_write_o = !tx_fifo_full_i;
        tx_data_o       = make_packet(r_field, w_option);
      end
      WAIT_ACK: begin
        rx_fifo_read_o = !rx_fifo_empty_i;
      end
      RETRY: begin
        if (w_next_state == FAIL) begin
          w_fail_field_d = r_field;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_field <= '0;
    end else begin
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_fail       <= w_fail_d;
      r_fail_field <= w_fail_field_d;
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign fail_o       = r_fail;
  assign fail_field_o = r_fail_field;

  // Sequence datapath: option snapshot, current field, retry count, received byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_field           <= '0;
      r_retry           <= '0;
      r_opt_data_width  <= '0;
      r_opt_stop_bits   <= '0;
      r_opt_parity_mode <= '0;
      r_rx_byte         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_field           <= DATA_WIDTH_ID;
            r_retry           <= '0;
            r_opt_data_width  <= data_width_i;
            r_opt_stop_bits   <= stop_bits_i;
            r_opt_parity_mode <= parity_mode_i;
          end
        end
        WAIT_ACK: begin
          if (!rx_fifo_empty_i) begin
            r_rx_byte <= rx_data_i;
          end
        end
        CHECK: begin
          if ((r_rx_byte == ACK_BYTE) && (r_field != PARITY_MODE_ID)) begin
            r_field <= r_field + ID_W'(1);
            r_retry <= '0;
          end
        end
        RETRY: begin
          r_retry <= w_retry_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
